toggle_reg_bank: RTL and testbench

TOGGLE_REG_BANK -- requirements
Module: toggle_reg_bank

---
 rtl/toggle_reg_bank.sv | 113 +++++++++++
 tb/tb_toggle_reg_bank.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_reg_bank
//  Description : Bank of WIDTH toggle cells. Each cell is a T flip-flop whose
//                toggle request comes from a per-mode source: an external
//                toggle vector, an up-count T-chain, a down-count T-chain or
//                a parallel-load difference term. Also provides a
//                combinational terminal-count flag and a registered one-cycle
//                wrap pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module toggle_reg_bank #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // Operation select encoding.
  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             wrap_q;
  logic             wrap_d;

  // ones_chain[i] is high when bits 0..i-1 are all 1 (up-count toggle term);
  // zeros_chain[i] is high when bits 0..i-1 are all 0 (down-count toggle
  // term). The final element of each chain doubles as the all-ones / all-zero
  // detector used by the terminal-count flag.
  logic [WIDTH:0]   ones_chain;
  logic [WIDTH:0]   zeros_chain;
  logic [WIDTH-1:0] toggle_req;

  assign ones_chain[0]  = 1'b1;
  assign zeros_chain[0] = 1'b1;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign ones_chain[i+1]  = ones_chain[i]  &  q_q[i];
      assign zeros_chain[i+1] = zeros_chain[i] & ~q_q[i];

      // Per-cell toggle request for the selected mode; load toggles exactly
      // the bits that differ from the load data.
      always_comb begin
        toggle_req[i] = 1'b0;
        unique case (mode)
          MODE_TOGGLE: toggle_req[i] = t[i];
          MODE_UP:     toggle_req[i] = ones_chain[i];
          MODE_DOWN:   toggle_req[i] = zeros_chain[i];
          MODE_LOAD:   toggle_req[i] = q_q[i] ^ d[i];
          default:     toggle_req[i] = 1'b0;
        endcase
      end
    end
  endgenerate

  // Terminal count: the next enabled counting edge will wrap. Depends only
  // on en, clr, mode and the current state.
  always_comb begin
    tc = 1'b0;
    if (en && !clr) begin
      if (mode == MODE_UP && ones_chain[WIDTH]) begin
        tc = 1'b1;
      end else if (mode == MODE_DOWN && zeros_chain[WIDTH]) begin
        tc = 1'b1;
      end
    end
  end

  // Next-state selection: clear beats enable; a disabled bank holds.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (clr) begin
      q_d    = '0;
      wrap_d = 1'b0;
    end else if (en) begin
      q_d    = q_q ^ toggle_req;
      // A wrap happens exactly when a counting edge is taken at terminal
      // count, so the registered pulse is the flag captured on that edge.
      wrap_d = tc;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= RST_VAL;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_toggle_reg_bank
//  Description : Self-checking bench for toggle_reg_bank (WIDTH=4). Two
//                instances share all inputs except reset: one with
//                RST_VAL=0000, one with RST_VAL=0011. A behavioural model
//                tracks both.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_reg_bank;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rst2_n;
  logic         en;
  logic         clr;
  logic [1:0]   mode;
  logic [W-1:0] t;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] q2;
  logic         tc;
  logic         tc2;
  logic         wrap;
  logic         wrap2;

  // Model state for each instance.
  logic [W-1:0] mq;
  logic [W-1:0] mq2;
  logic         mw;
  logic         mw2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  toggle_reg_bank #(.WIDTH(W), .RST_VAL(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
    .t(t), .d(d), .q(q), .tc(tc), .wrap(wrap)
  );

  toggle_reg_bank #(.WIDTH(W), .RST_VAL(4'b0011)) dut2 (
    .clk(clk), .rst_n(rst2_n), .en(en), .clr(clr), .mode(mode),
    .t(t), .d(d), .q(q2), .tc(tc2), .wrap(wrap2)
  );

  // Reference next-state: plain modular arithmetic on the bank value.
  function automatic logic [W:0] model_next(input logic [W-1:0] cur);
    int v;
    v = int'(cur);
    if (clr)           return {1'b0, 4'b0000};
    if (!en)           return {1'b0, cur};
    case (mode)
      2'b00:   return {1'b0, cur ^ t};
      2'b01:   return {(v == 15), 4'((v + 1) % 16)};
      2'b10:   return {(v == 0),  4'((v + 15) % 16)};
      default: return {1'b0, d};
    endcase
  endfunction

  function automatic logic model_tc(input logic [W-1:0] cur);
    return en && !clr && ((mode == 2'b01 && cur == 4'd15) ||
                          (mode == 2'b10 && cur == 4'd0));
  endfunction

  // Advance one clock edge and update the model from the pre-edge inputs.
  task automatic step();
    logic [W:0] n1, n2;
    n1 = model_next(mq);
    n2 = model_next(mq2);
    @(posedge clk);
    #1;
    if (rst_n)  begin mw  = n1[W]; mq  = n1[W-1:0]; end
    if (rst2_n) begin mw2 = n2[W]; mq2 = n2[W-1:0]; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    mq = 4'b0000; mq2 = 4'b0011; mw = 1'b0; mw2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; clr = 1'b0; mode = 2'($urandom_range(0, 3));
      t = 4'($urandom); d = 4'($urandom);
      step();
      n_total++;
      if (q !== 4'b0000 || wrap !== 1'b0) begin
        $display("FAIL reset_hold0: q=%b wrap=%b required q=0000 wrap=0", q, wrap);
      end else n_pass++;
      n_total++;
      if (q2 !== 4'b0011 || wrap2 !== 1'b0) begin
        $display("FAIL reset_hold3: q=%b wrap=%b required q=0011 wrap=0", q2, wrap2);
      end else n_pass++;
    end
    // Release away from the clock edge.
    en = 1'b0; clr = 1'b0; mode = 2'b00; t = '0; d = '0;
    rst_n = 1'b1; rst2_n = 1'b1;
  endtask

  task automatic test_toggle();
    logic [W-1:0] exp_seq [3];
    exp_seq[0] = 4'b0101; exp_seq[1] = 4'b0000; exp_seq[2] = 4'b0101;
    en = 1'b1; clr = 1'b0; mode = 2'b00; t = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (q !== exp_seq[i] || wrap !== 1'b0 || q !== mq) begin
        $display("FAIL toggle_seq%0d: q=%b wrap=%b required q=%b wrap=0", i, q, wrap, exp_seq[i]);
      end else n_pass++;
    end
    // Toggle all ones from 1111 to 0000 must not wrap.
    mode = 2'b11; d = 4'b1111; step();
    mode = 2'b00; t = 4'b1111; step();
    n_total++;
    if (q !== 4'b0000 || wrap !== 1'b0) begin
      $display("FAIL toggle_all_nowrap: q=%b wrap=%b required q=0000 wrap=0", q, wrap);
    end else n_pass++;
  endtask

  task automatic test_up_wrap();
    en = 1'b1; clr = 1'b0; mode = 2'b11; d = 4'b1110; step();
    mode = 2'b01; step();
    n_total++;
    if (q !== 4'b1111 || tc !== 1'b1 || wrap !== 1'b0) begin
      $display("FAIL up_tc: q=%b tc=%b wrap=%b required q=1111 tc=1 wrap=0", q, tc, wrap);
    end else n_pass++;
    step();
    n_total++;
    if (q !== 4'b0000 || wrap !== 1'b1 || tc !== 1'b0) begin
      $display("FAIL up_wrap: q=%b wrap=%b tc=%b required q=0000 wrap=1 tc=0", q, wrap, tc);
    end else n_pass++;
    step();
    n_total++;
    if (q !== 4'b0001 || wrap !== 1'b0) begin
      $display("FAIL up_after_wrap: q=%b wrap=%b required q=0001 wrap=0", q, wrap);
    end else n_pass++;
  endtask

  task automatic test_down_wrap();
    en = 1'b1; clr = 1'b0; mode = 2'b11; d = 4'b0001; step();
    mode = 2'b10; step();
    n_total++;
    if (q !== 4'b0000 || tc !== 1'b1 || wrap !== 1'b0) begin
      $display("FAIL down_tc: q=%b tc=%b wrap=%b required q=0000 tc=1 wrap=0", q, tc, wrap);
    end else n_pass++;
    step();
    n_total++;
    if (q !== 4'b1111 || wrap !== 1'b1) begin
      $display("FAIL down_wrap: q=%b wrap=%b required q=1111 wrap=1", q, wrap);
    end else n_pass++;
    step();
    n_total++;
    if (q !== 4'b1110 || wrap !== 1'b0) begin
      $display("FAIL down_after_wrap: q=%b wrap=%b required q=1110 wrap=0", q, wrap);
    end else n_pass++;
  endtask

  task automatic test_clr_load();
    en = 1'b1; mode = 2'b11; d = 4'b1010; clr = 1'b1; step();
    n_total++;
    if (q !== 4'b0000 || wrap !== 1'b0) begin
      $display("FAIL clr_wins: q=%b wrap=%b required q=0000 wrap=0", q, wrap);
    end else n_pass++;
    clr = 1'b0; step();
    n_total++;
    if (q !== 4'b1010) begin
      $display("FAIL load_after_clr: q=%b required q=1010", q);
    end else n_pass++;
    // Clear while sitting at terminal count suppresses tc and wrap.
    d = 4'b1111; step();
    mode = 2'b01; clr = 1'b1; #1;
    n_total++;
    if (tc !== 1'b0) begin
      $display("FAIL clr_masks_tc: tc=%b required 0", tc);
    end else n_pass++;
    step();
    n_total++;
    if (q !== 4'b0000 || wrap !== 1'b0) begin
      $display("FAIL clr_at_tc: q=%b wrap=%b required q=0000 wrap=0", q, wrap);
    end else n_pass++;
    clr = 1'b0;
  endtask

  task automatic test_en_gating();
    logic [W-1:0] exp_seq [3];
    logic         en_seq  [3];
    en_seq[0] = 1'b1; en_seq[1] = 1'b0; en_seq[2] = 1'b1;
    exp_seq[0] = 4'b0110; exp_seq[1] = 4'b0110; exp_seq[2] = 4'b0111;
    clr = 1'b0; en = 1'b1; mode = 2'b11; d = 4'b0101; step();
    mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      en = en_seq[i]; #1;
      if (!en_seq[i]) begin
        n_total++;
        if (tc !== 1'b0) begin
          $display("FAIL en_low_tc: tc=%b required 0", tc);
        end else n_pass++;
      end
      step();
      n_total++;
      if (q !== exp_seq[i] || wrap !== 1'b0) begin
        $display("FAIL en_gate%0d: q=%b wrap=%b required q=%b wrap=0", i, q, wrap, exp_seq[i]);
      end else n_pass++;
    end
    // en low at terminal count: no tc, hold, no wrap.
    en = 1'b1; mode = 2'b11; d = 4'b1111; step();
    en = 1'b0; mode = 2'b01; #1;
    n_total++;
    if (tc !== 1'b0) begin
      $display("FAIL en_low_tc_at_max: tc=%b required 0", tc);
    end else n_pass++;
    step();
    n_total++;
    if (q !== 4'b1111 || wrap !== 1'b0) begin
      $display("FAIL en_low_hold: q=%b wrap=%b required q=1111 wrap=0", q, wrap);
    end else n_pass++;
  endtask

  task automatic test_async_reset();
    // Second instance: reset mid-cycle during an up count at 0111.
    clr = 1'b0; en = 1'b1; mode = 2'b11; d = 4'b0111; step();
    mode = 2'b01;
    #2 rst2_n = 1'b0;
    #1;
    n_total++;
    if (q2 !== 4'b0011 || wrap2 !== 1'b0) begin
      $display("FAIL async_rst_val: q=%b wrap=%b required q=0011 wrap=0", q2, wrap2);
    end else n_pass++;
    mq2 = 4'b0011; mw2 = 1'b0;
    rst2_n = 1'b1;
    step();
    n_total++;
    if (q2 !== 4'b0100 || wrap2 !== 1'b0) begin
      $display("FAIL async_resume: q=%b wrap=%b required q=0100 wrap=0", q2, wrap2);
    end else n_pass++;
    // First instance: reset while the wrap pulse is high clears it at once.
    mode = 2'b11; d = 4'b1111; step();
    mode = 2'b01; step();
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (q !== 4'b0000 || wrap !== 1'b0) begin
      $display("FAIL async_rst_wrap: q=%b wrap=%b required q=0000 wrap=0", q, wrap);
    end else n_pass++;
    mq = 4'b0000; mw = 1'b0;
    rst_n = 1'b1;
    step();
    n_total++;
    if (q !== 4'b0001) begin
      $display("FAIL async_resume0: q=%b required q=0001", q);
    end else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      clr  = ($urandom_range(0, 19) == 0);
      mode = 2'($urandom_range(0, 3));
      t    = 4'($urandom);
      d    = 4'($urandom);
      #1;
      n_total++;
      if (tc !== model_tc(mq) || tc2 !== model_tc(mq2)) begin
        $display("FAIL rand_tc%0d: tc=%b tc2=%b required %b %b", i, tc, tc2, model_tc(mq), model_tc(mq2));
        errs++;
      end else n_pass++;
      // t and d must not affect tc.
      t = ~t; d = ~d; #1;
      n_total++;
      if (tc !== model_tc(mq)) begin
        $display("FAIL rand_tc_indep%0d: tc=%b required %b", i, tc, model_tc(mq));
      end else n_pass++;
      step();
      n_total++;
      if (q !== mq || wrap !== mw || q2 !== mq2 || wrap2 !== mw2) begin
        $display("FAIL rand_state%0d: q=%b wrap=%b q2=%b wrap2=%b required %b %b %b %b",
                 i, q, wrap, q2, wrap2, mq, mw, mq2, mw2);
      end else n_pass++;
    end
  endtask

  initial begin
    en = 1'b0; clr = 1'b0; mode = 2'b00; t = '0; d = '0;
    rst_n = 1'b1; rst2_n = 1'b1;
    #2;
    test_reset();
    test_toggle();
    test_up_wrap();
    test_down_wrap();
    test_clr_load();
    test_en_gating();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
